// File: rtl/cpu_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : cpu_pkg
// Purpose  : Shared definitions for the 16-bit core front end: condition
//            codes, flag bit positions, branch types and the PC sequencer
//            state encoding.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
package cpu_pkg;

   // Branch condition codes
   localparam logic [2:0] COND_NEQ    = 3'b000;
   localparam logic [2:0] COND_EQ     = 3'b001;
   localparam logic [2:0] COND_GT     = 3'b010;
   localparam logic [2:0] COND_LT     = 3'b011;
   localparam logic [2:0] COND_GTE    = 3'b100;
   localparam logic [2:0] COND_LTE    = 3'b101;
   localparam logic [2:0] COND_OVFL   = 3'b110;
   localparam logic [2:0] COND_UNCOND = 3'b111;

   // Flag register bit positions, packed as {Z,V,N}
   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_N = 0;

   // Branch flavours
   localparam logic BR_TYPE_B  = 1'b0;   // PC-relative immediate
   localparam logic BR_TYPE_BR = 1'b1;   // register target

   // PC sequencer states
   typedef enum logic [0:0] {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pc_sequencer_if
// Purpose  : Bundles the decode-side branch/halt/flag inputs and the fetch-
//            side outputs of the PC sequencer.
// Ports    : master - decode/fetch side (drives requests, observes PC)
//            slave  - pc_sequencer side
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
interface pc_sequencer_if #(
   parameter int CNT_W = 16
);
   // decode -> sequencer
   logic              stall_i;
   logic              br_valid_i;
   logic              br_type_i;
   logic [2:0]        br_cond_i;
   logic [8:0]        br_imm_i;
   logic [15:0]       br_pc_i;
   logic [15:0]       br_reg_i;
   logic              halt_i;
   logic [2:0]        flag_we_i;
   logic [2:0]        flag_in_i;
   // sequencer -> fetch/decode
   logic [15:0]       pc_o;
   logic              fetch_valid_o;
   logic              flush_o;
   logic              halted_o;
   logic [2:0]        flags_o;
   logic [CNT_W-1:0]  taken_cnt_o;

   modport master (
      output stall_i, br_valid_i, br_type_i, br_cond_i, br_imm_i,
             br_pc_i, br_reg_i, halt_i, flag_we_i, flag_in_i,
      input  pc_o, fetch_valid_o, flush_o, halted_o, flags_o, taken_cnt_o
   );

   modport slave (
      input  stall_i, br_valid_i, br_type_i, br_cond_i, br_imm_i,
             br_pc_i, br_reg_i, halt_i, flag_we_i, flag_in_i,
      output pc_o, fetch_valid_o, flush_o, halted_o, flags_o, taken_cnt_o
   );

endinterface : pc_sequencer_if
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : branch_cond_eval
// Purpose  : Combinational branch condition evaluator.
// Ports    : i_cond   - condition code
//            i_flags  - effective {Z,V,N}
//            o_taken  - condition holds
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module branch_cond_eval
   import cpu_pkg::*;
(
   input  wire logic [2:0] i_cond,
   input  wire logic [2:0] i_flags,
   output logic            o_taken
);

   logic w_z;
   logic w_v;
   logic w_n;

   assign w_z = i_flags[FLAG_Z];
   assign w_v = i_flags[FLAG_V];
   assign w_n = i_flags[FLAG_N];

   always_comb begin
      o_taken = 1'b0;
      case (i_cond)
         COND_NEQ    : o_taken = ~w_z;
         COND_EQ     : o_taken =  w_z;
         COND_GT     : o_taken = ~w_z & ~w_n;
         COND_LT     : o_taken =  w_n;
         COND_GTE    : o_taken =  w_z | ~w_n;
         COND_LTE    : o_taken =  w_z |  w_n;
         COND_OVFL   : o_taken =  w_v;
         COND_UNCOND : o_taken =  1'b1;
         default     : o_taken =  1'b0;
      endcase
   end

endmodule : branch_cond_eval
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pc_sequencer
// Purpose  : Architectural PC and {Z,V,N} flag register of the 16-bit core.
//            Selects hold / +2 / PC-relative / register branch / halt each
//            cycle, evaluates branch conditions with same-cycle flag bypass,
//            raises the IF/ID flush and counts taken branches.
// Ports    : clk   - core clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - pc_sequencer_if.slave (decode inputs, fetch outputs)
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module pc_sequencer
   import cpu_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          CNT_W    = 16
)(
   input  wire logic      clk,
   input  wire logic      rst_n,
   pc_sequencer_if.slave  bus
);

   localparam logic [15:0]      c_PC_STEP = 16'd2;
   localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            r_state;
   state_t            w_state_nxt;
   logic [15:0]       r_pc;
   logic [15:0]       w_pc_nxt;
   logic [2:0]        r_flags;
   logic [2:0]        w_flags_nxt;
   logic [2:0]        w_eff_flags;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              r_fetch_valid;
   logic              w_cond_true;
   logic              w_taken;
   logic              w_flush;
   logic [15:0]       w_imm_off;
   logic [15:0]       w_target;

   // Per-bit flag writes and the bypass view used for condition evaluation.
   for (genvar gi = 0; gi < 3; gi++) begin : g_flag
      assign w_flags_nxt[gi] = bus.flag_we_i[gi] ? bus.flag_in_i[gi] : r_flags[gi];
      assign w_eff_flags[gi] = bus.flag_we_i[gi] ? bus.flag_in_i[gi] : r_flags[gi];
   end

   branch_cond_eval u_cond (
      .i_cond  (bus.br_cond_i),
      .i_flags (w_eff_flags),
      .o_taken (w_cond_true)
   );

   // Word offset: sign-extend the 9-bit immediate and scale by 2.
   assign w_imm_off = {{6{bus.br_imm_i[8]}}, bus.br_imm_i, 1'b0};
   assign w_target  = (bus.br_type_i == BR_TYPE_BR) ? bus.br_reg_i
                                                    : (bus.br_pc_i + c_PC_STEP + w_imm_off);

   assign w_taken = bus.br_valid_i & ~bus.stall_i & (r_state == RUN) & w_cond_true;

   // Next-state / next-PC selection
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_cnt_nxt   = r_cnt;
      w_flush     = 1'b0;
      case (r_state)
         RUN: begin
            if (w_taken) begin
               // A same-cycle halt is on the wrong path and is dropped.
               w_pc_nxt  = w_target;
               w_cnt_nxt = r_cnt + c_CNT_ONE;
               w_flush   = 1'b1;
            end else if (bus.halt_i && !bus.stall_i) begin
               w_state_nxt = HALTED;
            end else if (bus.stall_i) begin
               w_pc_nxt = r_pc;
            end else begin
               w_pc_nxt = r_pc + c_PC_STEP;
            end
         end
         HALTED: begin
            w_state_nxt = HALTED;
         end
         default: begin
            w_state_nxt = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= RUN;
         r_pc          <= RESET_PC;
         r_flags       <= 3'b000;
         r_cnt         <= '0;
         r_fetch_valid <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_flags       <= w_flags_nxt;   // older instructions still retire while halted
         r_cnt         <= w_cnt_nxt;
         // Low for the first cycle out of reset and whenever halted.
         r_fetch_valid <= (w_state_nxt == RUN);
      end
   end

   assign bus.pc_o          = r_pc;
   assign bus.fetch_valid_o = r_fetch_valid;
   assign bus.flush_o       = w_flush;
   assign bus.halted_o      = (r_state == HALTED);
   assign bus.flags_o       = r_flags;
   assign bus.taken_cnt_o   = r_cnt;

endmodule : pc_sequencer
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the architectural PC register and the Z/V/N flag register of the 16-bit core. Each cycle it chooses the next PC: hold, sequential +2, PC-relative branch, register branch, or halt. It evaluates branch conditions against the flag register (with same-cycle bypass), drives the fetch address, and signals decode/IF flushes. It also keeps a taken-branch counter for debug.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
CNT_W, 16, width of the taken-branch counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  hazard stall; hold PC
br_valid_i  in  1  decode-stage instruction is a branch (B or BR)
br_type_i  in  1  0 = B (PC-relative immediate), 1 = BR (register target)
br_cond_i  in  3  condition code
br_imm_i  in  9  signed word offset for B
br_pc_i  in  16  PC of the branch instruction
br_reg_i  in  16  register target for BR
halt_i  in  1  decode-stage HLT
flag_we_i  in  3  per-bit flag write enable {Z,V,N}
flag_in_i  in  3  new flag values {Z,V,N}
pc_o  out  16  fetch address (registered PC)
fetch_valid_o  out  1  fetch at pc_o is valid
flush_o  out  1  squash IF/ID contents this cycle
halted_o  out  1  core halted
flags_o  out  3  registered {Z,V,N}
taken_cnt_o  out  CNT_W  count of taken branches

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, flags=3'b000, state=RUN, taken_cnt=0, fetch_valid_o=0 in the first cycle after release, then 1. flush_o=0, halted_o=0.
- Flag bits: Z=[2], V=[1], N=[0]. Each bit is written independently when its flag_we bit is 1. Flags still update in HALTED (retiring older instructions).
- Effective flags for condition evaluation: eff[i] = flag_we_i[i] ? flag_in_i[i] : flags_q[i] (same-cycle bypass).
- Conditions (taken when): 000 NEQ !Z; 001 EQ Z; 010 GT !Z&!N; 011 LT N; 100 GTE Z|!N; 101 LTE Z|N; 110 OVFL V; 111 always.
- taken = br_valid_i & !stall_i & state==RUN & cond_true.
- Target: B = br_pc_i + 2 + (sext(br_imm_i)<<1); BR = br_reg_i. All arithmetic is mod 2^16; overflow is ignored.
- FSM states: RUN, HALTED.
- RUN, next-PC priority (highest first):
  - taken: pc <= target, flush_o=1 combinationally this cycle, taken_cnt++ (wraps).
  - halt_i & !stall_i: pc holds, state <= HALTED.
  - stall_i: pc holds; flush_o=0.
  - else: pc <= pc+2 (0xFFFE wraps to 0x0000).
- A taken branch with halt_i in the same cycle: branch wins, halt is dropped (wrong path).
- A not-taken branch behaves as the sequential +2 case.
- HALTED: pc frozen, fetch_valid_o=0, halted_o=1, flush_o=0. br_valid_i/halt_i/stall_i are ignored. Exit only via reset.
- Reset mid-operation: immediately returns to reset values regardless of state; no pending redirect survives.
- pc_o, flags_o, halted_o, taken_cnt_o are registered. flush_o is combinational from inputs and state.

Decomposition:
- Shared package cpu_pkg:
  - condition-code constants (COND_NEQ..COND_UNCOND)
  - flag bit indices (FLAG_Z=2, FLAG_V=1, FLAG_N=0)
  - state enum {RUN, HALTED}
  - BR_TYPE_B/BR_TYPE_BR constants
- Sub-module branch_cond_eval: combinational, cond[2:0] + eff_flags[2:0] -> taken. It is reused by verification as the reference model.

Test Plan:
- Reset release, no branches, 4 cycles -> pc_o 0x0000, 0x0002, 0x0004, 0x0006; fetch_valid_o=0 only in the first cycle; flags_o=000.
- flags_q Z=1; B EQ, br_pc=0x0010, imm=9'h1FE (-2) -> next pc 0x000E, flush_o=1 that cycle, taken_cnt=1. Same with NEQ -> pc+2, flush_o=0.
- flag_we=3'b100, flag_in Z=1 while flags_q Z=0, B EQ in the same cycle -> taken via bypass; flags_o Z=1 next cycle.
- BR always, br_reg=0x1234, stall_i=1 for 2 cycles then 0 -> pc held for 2 cycles, then 0x1234, flush_o only in the release cycle.
- halt_i with pc=0x0040 -> halted_o=1 next cycle, pc_o stays 0x0040, fetch_valid_o=0. A later br_valid_i always branch is ignored. rst_n pulse -> pc 0x0000, RUN.
- pc=0xFFFE sequential -> 0x0000. B imm=9'h0FF from br_pc 0xFFF0 -> 0x01F0 (wrap). Taken branch with halt_i in the same cycle -> redirect, no halt.
